t_ff: RTL and testbench

T_FF -- requirements
Module: t_ff

---
 rtl/t_ff.sv | 47 ++++
 tb/tb_t_ff.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/t_ff.sv
// Bank of WIDTH independent toggle flip-flops with asynchronous active-high reset.
// nq is the combinational complement of q, so it never lags q.
module t_ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] toggle_s;
  logic [WIDTH-1:0] q_next_s;

  // Per-bit toggle decode: only a definite 1 toggles; X/Z falls to the hold branch.
  always_comb begin
    toggle_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (t[i] == 1'b1) begin
        toggle_s[i] = 1'b1;
      end else begin
        toggle_s[i] = 1'b0;
      end
    end
  end

  // Next-state: invert toggled bits, hold the rest.
  always_comb begin
    q_next_s = q_r ^ toggle_s;
  end

  // State register; reset takes priority over any toggle on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= RESET_VAL;
    end else begin
      q_r <= q_next_s;
    end
  end

  assign q  = q_r;
  assign nq = ~q_r;

endmodule

// File: tb/tb_t_ff.sv
// Scoreboard bench for t_ff: a WIDTH=1 instance and a WIDTH=4 / RESET_VAL=4'b1010
// instance share clk, rst and stimulus; a per-bit arithmetic model predicts q.
module tb_t_ff;

  typedef struct {
    logic [0:0] q1;
    logic [3:0] q4;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [0:0] t1;
  logic [0:0] q1;
  logic [0:0] nq1;
  logic [3:0] t4;
  logic [3:0] q4;
  logic [3:0] nq4;

  int tests;
  int fails;
  bit done;

  exp_t exp_q[$];
  exp_t async_q[$];
  event async_ev;

  // Reference model: one integer (0/1) per bit.
  int m1;
  int m4[4];
  int rv4[4] = '{0, 1, 0, 1}; // bit index 0..3 of 4'b1010

  t_ff #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .t(t1), .q(q1), .nq(nq1)
  );

  t_ff #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
    .clk(clk), .rst(rst), .t(t4), .q(q4), .nq(nq4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model_pack();
    exp_t e;
    e.q1 = m1[0];
    for (int i = 0; i < 4; i++) e.q4[i] = m4[i][0];
    return e;
  endfunction

  function automatic void model_reset();
    m1 = 0;
    for (int i = 0; i < 4; i++) m4[i] = rv4[i];
  endfunction

  function automatic void model_step(input logic [0:0] a, input logic [3:0] b);
    m1 = (m1 + int'(a[0])) % 2;
    for (int i = 0; i < 4; i++) m4[i] = (m4[i] + int'(b[i])) % 2;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, " q1"},  {3'b000, q1},  {3'b000, e.q1});
    check({tag, " nq1"}, {3'b000, nq1}, {3'b000, ~e.q1});
    check({tag, " q4"},  q4,  e.q4);
    check({tag, " nq4"}, nq4, ~e.q4);
  endtask

  // Edge monitor: 1 ns after each rising edge, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare_all("edge", e);
      end else if (!done) begin
        tests++;
        fails++;
        $display("FAIL edge_underflow: no expectation queued at %0t", $time);
      end
    end
  end

  // Async monitor: compares immediately when stimulus signals a between-edge reset.
  initial begin
    exp_t e;
    forever begin
      @(async_ev);
      if (async_q.size() > 0) begin
        e = async_q.pop_front();
        compare_all("async", e);
      end
    end
  end

  task automatic cycle(input bit r, input bit pulse, input logic [0:0] a, input logic [3:0] b);
    @(negedge clk);
    if (pulse) begin
      rst = 1'b1;
      #1;
      model_reset();
      async_q.push_back(model_pack());
      ->async_ev;
      #1;
    end
    rst = r;
    t1  = a;
    t4  = b;
    if (r) model_reset();
    else   model_step(a, b);
    exp_q.push_back(model_pack());
  endtask

  initial begin
    tests = 0;
    fails = 0;
    done  = 1'b0;
    rst   = 1'b1;
    t1    = 1'b1;
    t4    = 4'b1111;
    // Reset with no clock edge yet.
    #1;
    model_reset();
    async_q.push_back(model_pack());
    ->async_ev;
    exp_q.push_back(model_pack());

    cycle(1'b1, 1'b0, 1'b1, 4'b1111); // held in reset, toggles ignored
    cycle(1'b0, 1'b0, 1'b0, 4'b0110); // hold on q1; q4 -> 1100
    cycle(1'b0, 1'b0, 1'b1, 4'b0000); // q1 -> 1
    cycle(1'b0, 1'b0, 1'b1, 4'b0000); // q1 -> 0
    cycle(1'b0, 1'b0, 1'b1, 4'b1111); // q1 -> 1
    cycle(1'b0, 1'b0, 1'b0, 4'b0000); // hold at 1
    cycle(1'b0, 1'b1, 1'b0, 4'b0000); // async pulse between edges
    cycle(1'b0, 1'b0, 1'b1, 4'b1111); // first edge after reset toggles from reset value
    cycle(1'b1, 1'b0, 1'b1, 4'b1111); // reset overrides toggle on same edge
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b1, 4'b1111); // clk/2 square wave

    for (int k = 0; k < 300; k++) begin
      logic [0:0] ra;
      logic [3:0] rb;
      bit rr;
      bit rp;
      ra = 1'($urandom_range(1, 0));
      rb = 4'($urandom_range(15, 0));
      rr = ($urandom_range(15, 0) == 0);
      rp = ($urandom_range(15, 0) == 0);
      cycle(rr, rp, ra, rb);
    end

    @(posedge clk);
    #2;
    done = 1'b1;
    tests++;
    if (exp_q.size() != 0 || async_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d edge and %0d async expectations left, expected 0",
               exp_q.size(), async_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
